// File: rtl/zone_pkg.sv
// rtl/zone_pkg.sv - shared constants, FSM state type and clamp helper for zone gray shift-out
package zone_pkg;

  localparam int ZONES   = 360;
  localparam int GRAY_W  = 16;
  localparam int ZONE_AW = 10;
  localparam logic [GRAY_W-1:0] MAX_DUTY = 16'hFFF0;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  // ceiling applied to a zone word before it is shifted out
  function automatic logic [GRAY_W-1:0] clamp_duty(input logic [GRAY_W-1:0] w);
    return (w > MAX_DUTY) ? MAX_DUTY : w;
  endfunction

endpackage

// File: rtl/zone_gray_shiftout_if.sv
// rtl/zone_gray_shiftout_if.sv - zone-gray write stream (sdbpflag / wtaddr / wtdina) interface
interface zone_gray_shiftout_if;
  import zone_pkg::*;

  logic               sdbpflag;
  logic               wt_valid;
  logic [ZONE_AW-1:0] wtaddr;
  logic [GRAY_W-1:0]  wtdina;

  modport master (output sdbpflag, wt_valid, wtaddr, wtdina);
  modport slave  (input  sdbpflag, wt_valid, wtaddr, wtdina);

endinterface

// File: rtl/zone_ram_dp.sv
// rtl/zone_ram_dp.sv - ping-pong zone RAM, 2 banks of ZONES words, 1W/1R, read latency 1
module zone_ram_dp
  import zone_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic               wr_bank,
  input  logic [ZONE_AW-1:0] wr_zone,
  input  logic [GRAY_W-1:0]  wr_data,
  input  logic               rd_bank,
  input  logic [ZONE_AW-1:0] rd_zone,
  output logic [GRAY_W-1:0]  rd_data
);

  localparam int DEPTH = 2 * ZONES;
  localparam int AW    = $clog2(DEPTH);

  logic [GRAY_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;

  // bank selects the upper or lower half of the array; zone is the offset inside it
  assign wr_idx = (wr_bank ? AW'(ZONES) : AW'(0)) + AW'(wr_zone);
  assign rd_idx = (rd_bank ? AW'(ZONES) : AW'(0)) + AW'(rd_zone);

  // synchronous write and registered read
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/zone_gray_shiftout.sv
// rtl/zone_gray_shiftout.sv - captures a zone gray frame and shifts it serially to the LED driver; optional ZONE_CLAMP_EN caps each word at MAX_DUTY
module zone_gray_shiftout
  import zone_pkg::*;
#(
  parameter int SCLK_DIV  = 4,
  parameter int LATCH_CYC = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  zone_gray_shiftout_if.slave  wr,
  output logic                 led_sclk,
  output logic                 led_sdo,
  output logic                 led_latch,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_short,
  output logic                 err_addr
);

  localparam int          BIT_W = $clog2(GRAY_W);
  localparam logic [15:0] TDIV  = 16'(SCLK_DIV - 1);
  localparam logic [15:0] TLAT  = 16'(LATCH_CYC - 1);

  state_t             state, state_n;
  logic [ZONE_AW-1:0] zone, zone_n;
  logic [BIT_W-1:0]   bit_idx, bit_n;
  logic               half, half_n;
  logic [15:0]        tmr, tmr_n;
  logic [GRAY_W-1:0]  shreg;
  logic [GRAY_W-1:0]  rd_data;
  logic [GRAY_W-1:0]  word_in;

  logic               sdbpflag_d1;
  logic [ZONE_AW-1:0] cnt;
  logic               cap_bank;
  logic               pending;

  logic edge_det, full, addr_ok, we, swap_go, wr_bank;

  assign edge_det = wr.sdbpflag & ~sdbpflag_d1;
  assign full     = (cnt == ZONE_AW'(ZONES));
  assign addr_ok  = (wr.wtaddr < ZONE_AW'(ZONES));
  assign we       = wr.wt_valid & addr_ok;
  // a full frame closing while idle swaps at once, so the edge-cycle write already lands in the new capture bank
  assign swap_go  = (state == IDLE) & (pending | (edge_det & full));
  assign wr_bank  = cap_bank ^ swap_go;

  // read address is looked up one cycle ahead so the word is on rd_data during LOAD
  zone_ram_dp u_ram (
    .clk     (clk),
    .we      (we),
    .wr_bank (wr_bank),
    .wr_zone (wr.wtaddr),
    .wr_data (wr.wtdina),
    .rd_bank (~wr_bank),
    .rd_zone (zone_n),
    .rd_data (rd_data)
  );

`ifdef ZONE_CLAMP_EN
  assign word_in = clamp_duty(rd_data);
`else
  assign word_in = rd_data;
`endif

  // capture counter, frame edge detect, bank swap control and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      sdbpflag_d1 <= 1'b0;
      cnt         <= '0;
      cap_bank    <= 1'b0;
      pending     <= 1'b0;
      err_short   <= 1'b0;
      err_addr    <= 1'b0;
    end else begin
      sdbpflag_d1 <= wr.sdbpflag;
      err_short   <= edge_det & ~full;
      if (wr.wt_valid && !addr_ok) err_addr <= 1'b1;
      if (edge_det)                cnt <= we ? ZONE_AW'(1) : '0;
      else if (we && !full)        cnt <= cnt + 1'b1;
      cap_bank <= cap_bank ^ swap_go;
      if (swap_go)                 pending <= 1'b0;
      else if (edge_det && full)   pending <= 1'b1;
    end
  end

  // shift FSM state, counters, shift register and frame_done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      zone       <= '0;
      bit_idx    <= '0;
      half       <= 1'b0;
      tmr        <= '0;
      shreg      <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      zone       <= zone_n;
      bit_idx    <= bit_n;
      half       <= half_n;
      tmr        <= tmr_n;
      frame_done <= (state == LATCH) && (tmr == TLAT);
      if (state == LOAD)                                shreg <= word_in;
      else if (state == SHIFT && half && tmr == TDIV)   shreg <= shreg << 1;
    end
  end

  // next-state: LOAD one word, SHIFT its bits low-half then high-half, LATCH after the last zone
  always_comb begin
    state_n = state;
    zone_n  = zone;
    bit_n   = bit_idx;
    half_n  = half;
    tmr_n   = tmr;
    case (state)
      IDLE: begin
        if (swap_go) begin
          state_n = LOAD;
          zone_n  = '0;
        end
      end
      LOAD: begin
        state_n = SHIFT;
        bit_n   = BIT_W'(GRAY_W - 1);
        half_n  = 1'b0;
        tmr_n   = '0;
      end
      SHIFT: begin
        if (tmr == TDIV) begin
          tmr_n = '0;
          if (!half) begin
            half_n = 1'b1;
          end else begin
            half_n = 1'b0;
            if (bit_idx != '0)                     bit_n = bit_idx - 1'b1;
            else if (zone != ZONE_AW'(ZONES - 1)) begin
              zone_n  = zone + 1'b1;
              state_n = LOAD;
            end else                               state_n = LATCH;
          end
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      LATCH: begin
        if (tmr == TLAT) begin
          state_n = IDLE;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign led_sclk  = (state == SHIFT) & half;
  assign led_sdo   = (state == SHIFT) & shreg[GRAY_W-1];
  assign led_latch = (state == LATCH);
  assign busy      = (state != IDLE);

endmodule
